// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial stage that feeds a bit-serial detector with one continuous stream.
// Accepts WIDTH-bit words on valid/ready and emits them one bit per clock on x/x_valid.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic             accept;

    // The bit that goes out next, and what remains once it has gone.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? (v << 1) : (v >> 1);
    endfunction

    // Ready on the last-bit cycle lets the next word follow with no bubble.
    assign in_ready = rst && !flush && ((state == IDLE) || (cnt == CNT_LAST));
    assign accept   = in_valid && in_ready;

    // NOTE: every register here is written with <= so all of them see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the shift register is datapath, but it is cleared too so no stale word survives reset.
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= '0;
            sreg    <= '0;
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
        end else if (accept) begin
            state   <= SHIFT;
            cnt     <= '0;
            sreg    <= advance(in_data);
            x       <= head(in_data);
            x_valid <= 1'b1;
            last    <= 1'b0;
            busy    <= 1'b1;
        end else if (state == SHIFT) begin
            if (cnt == CNT_LAST) begin
                state   <= IDLE;
                cnt     <= '0;
                x       <= IDLE_BIT;
                x_valid <= 1'b0;
                last    <= 1'b0;
                busy    <= 1'b0;
            end else begin
                cnt  <= cnt + 1'b1;
                sreg <= advance(sreg);
                x    <= head(sreg);
                last <= (cnt == CNT_PEN);
            end
        end
    end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus and are
// checked cycle by cycle against a queue of expected {bit,last} entries.
module tb_serial_bit_feeder;

    localparam int W = 8;

    typedef struct {
        logic b;
        logic l;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;

    logic rdy_m, x_m, xv_m, last_m, busy_m;
    logic rdy_l, x_l, xv_l, last_l, busy_l;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t q_m[$];
    ent_t q_l[$];
    logic [W-1:0] cap_m, cap_l;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .flush(flush), .x(x_m), .x_valid(xv_m), .last(last_m), .busy(busy_m)
    );

    serial_bit_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .flush(flush), .x(x_l), .x_valid(xv_l), .last(last_l), .busy(busy_l)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = (q_m.size() > 0);
        check("m.x_valid", xv_m, ev);
        check("m.busy", busy_m, ev);
        check("m.x", x_m, ev ? q_m[0].b : 1'b0);
        check("m.last", last_m, ev ? q_m[0].l : 1'b0);
        ev = (q_l.size() > 0);
        check("l.x_valid", xv_l, ev);
        check("l.busy", busy_l, ev);
        check("l.x", x_l, ev ? q_l[0].b : 1'b0);
        check("l.last", last_l, ev ? q_l[0].l : 1'b0);
        if (xv_m === 1'b1) cap_m = {cap_m[W-2:0], x_m};
        if (xv_l === 1'b1) cap_l = {cap_l[W-2:0], x_l};
    endtask

    // One clock: check registered outputs, apply inputs, check ready, advance the model.
    task automatic step(input logic r, input logic v, input logic f, input logic [W-1:0] d);
        logic exp_rdy_m, exp_rdy_l;
        @(negedge clk);
        check_outputs();
        rst      = r;
        in_valid = v;
        flush    = f;
        in_data  = d;
        #1;
        exp_rdy_m = r && !f && (q_m.size() <= 1);
        exp_rdy_l = r && !f && (q_l.size() <= 1);
        check("m.in_ready", rdy_m, exp_rdy_m);
        check("l.in_ready", rdy_l, exp_rdy_l);
        @(posedge clk);
        if (!r || f) begin
            q_m.delete();
            q_l.delete();
        end else begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (v && exp_rdy_m)
                for (int i = 0; i < W; i++) q_m.push_back('{b: d[W-1-i], l: (i == W-1)});
            if (v && exp_rdy_l)
                for (int i = 0; i < W; i++) q_l.push_back('{b: d[i], l: (i == W-1)});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        cap_m = '0;
        cap_l = '0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, 1'b0, 8'hA5);   // in_ready held low during reset
        idle(2);

        // Single word, MSB first
        cap_m = '0;
        step(1'b1, 1'b1, 1'b0, 8'b10111011);
        idle(10);
        check("t1.stream_msb", cap_m, 8'b10111011);

        // Back-to-back words, in_valid held high
        step(1'b1, 1'b1, 1'b0, 8'hB8);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, (i < 8) ? 8'hB8 : 8'h5C);
        idle(18);

        // Backpressure: new word offered from the 3rd bit until taken
        step(1'b1, 1'b1, 1'b0, 8'h3C);
        idle(1);
        for (int i = 2; i <= 7; i++) step(1'b1, (i >= 3), 1'b0, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 8'hFF);
        idle(10);

        // Reset after three bits, then a fresh word right after release
        step(1'b1, 1'b1, 1'b0, 8'hC3);
        idle(3);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 8'h96);
        idle(10);

        // Flush together with an offered word during bit 5
        step(1'b1, 1'b1, 1'b0, 8'hE7);
        idle(5);
        step(1'b1, 1'b1, 1'b1, 8'h81);
        idle(3);

        // LSB first stream
        cap_l = '0;
        step(1'b1, 1'b1, 1'b0, 8'b00011101);
        idle(10);
        check("t6.stream_lsb", cap_l, 8'b10111000);

        // Randomized traffic with occasional reset and flush
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, W'($urandom));
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
